// File: rtl/uart_tx_arbiter_if.sv
// Requester byte-stream handshake plus uart write port shared by the arbiter.
// The arbiter is the slave; the requesters and the uart sit on the master side.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_din;
  logic           uart_wr_en;
  logic           uart_tx_busy;

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, uart_din, uart_wr_en
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, uart_din, uart_wr_en
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter among N byte requesters,
// with optional packet lock and a watchdog on the uart tx_busy response.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int BUSY_TO = 8,
  parameter int LOCK_EN = 1
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             enable,
  uart_tx_arbiter_if.slave bus,
  output logic [IDW-1:0]   grant_id,
  output logic             locked,
  output logic             err_busy_to,
  input  logic             err_clr
);

  localparam int TW = (BUSY_TO < 2) ? 1 : $clog2(BUSY_TO);

  typedef enum logic [1:0] {
    SEL       = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t         state_r;
  logic [IDW-1:0] ptr_r;
  logic [TW-1:0]  timer_r;
  logic [IDW:0]   pick_s;
  logic           cand_ok_s;
  logic [IDW-1:0] cand_id_s;
  logic           accept_s;

  // First valid requester at or after p, wrapping mod N; MSB flags a hit.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] v, input logic [IDW-1:0] p);
    logic [IDW:0]   r;
    logic [IDW-1:0] idx;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDW'((int'(p) + i) % N);
      r   = v[idx] ? {1'b1, idx} : r;
    end
    return r;
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] g);
    if (g == IDW'(N - 1)) begin
      return '0;
    end else begin
      return g + IDW'(1);
    end
  endfunction

  // Candidate selection and the combinational one-hot accept strobe.
  always_comb begin
    pick_s    = rr_pick(bus.req_valid, ptr_r);
    cand_ok_s = 1'b0;
    cand_id_s = grant_id;
    if (locked) begin
      cand_ok_s = 1'b1;
      cand_id_s = grant_id;
    end else if (enable) begin
      cand_ok_s = pick_s[IDW];
      cand_id_s = pick_s[IDW-1:0];
    end else begin
      cand_ok_s = 1'b0;
      cand_id_s = grant_id;
    end
    // Gated by rst so no strobe leaks out while the state is forced to SEL.
    accept_s = !rst && (state_r == SEL) && cand_ok_s &&
               bus.req_valid[cand_id_s] && !bus.uart_tx_busy;
    if (accept_s) begin
      bus.req_ready = {{(N-1){1'b0}}, 1'b1} << cand_id_s;
    end else begin
      bus.req_ready = '0;
    end
  end

  // Transfer sequencer: accept, single-cycle write, then follow tx_busy.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_r        <= SEL;
      ptr_r          <= '0;
      timer_r        <= '0;
      grant_id       <= '0;
      locked         <= 1'b0;
      err_busy_to    <= 1'b0;
      bus.uart_din   <= 8'h00;
      bus.uart_wr_en <= 1'b0;
    end else begin
      if (err_clr) begin
        err_busy_to <= 1'b0;
      end
      case (state_r)
        SEL: begin
          if (accept_s) begin
            bus.uart_din   <= bus.req_data[{cand_id_s, 3'b000} +: 8];
            bus.uart_wr_en <= 1'b1;
            grant_id       <= cand_id_s;
            if ((LOCK_EN != 0) && !bus.req_last[cand_id_s]) begin
              locked <= 1'b1;
            end else begin
              locked <= 1'b0;
              ptr_r  <= next_id(cand_id_s);
            end
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          bus.uart_wr_en <= 1'b0;
          timer_r        <= '0;
          state_r        <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.uart_tx_busy) begin
            state_r <= WAIT_DONE;
          end else if (timer_r == TW'(BUSY_TO - 1)) begin
            // Placed after the err_clr clear so a coincident set wins.
            err_busy_to <= 1'b1;
            state_r     <= SEL;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!bus.uart_tx_busy) begin
            state_r <= SEL;
          end
        end
        default: begin
          bus.uart_wr_en <= 1'b0;
          state_r        <= SEL;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart transmitter among N byte-stream requesters. Each requester presents bytes on a valid/ready handshake, with an optional packet lock (req_last) so multi-byte messages are not interleaved. The block drives the uart din/wr_en inputs and sequences on tx_busy. It sits between on-chip message sources and the uart instance.

Parameters:
N, 4, number of requesters (2..8)
IDW, 2, width of grant_id; must equal clog2(N)
BUSY_TO, 8, max cycles after wr_en to see tx_busy rise before flagging error
LOCK_EN, 1, 1 = hold grant until req_last byte; 0 = re-arbitrate every byte

Ports:
clk_50m  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-high reset
enable  in  1  permits starting new packets
req_valid  in  N  per-requester byte valid
req_data  in  8*N  byte for requester i at [8i+7:8i]
req_last  in  N  byte is last of packet
req_ready  out  N  one-hot accept strobe
uart_din  out  8  to uart din
uart_wr_en  out  1  to uart wr_en, single-cycle pulse
uart_tx_busy  in  1  from uart tx_busy
grant_id  out  IDW  requester of the current/last accepted byte
locked  out  1  packet lock held
err_busy_to  out  1  sticky: tx_busy never rose after a write
err_clr  in  1  clears err_busy_to

Behaviour:
- One clock, clk_50m; rst asynchronous active-high.
- Reset: state=SEL, req_ready=0, uart_din=0, uart_wr_en=0, grant_id=0, locked=0, err_busy_to=0, rr pointer=0. Reset asserted mid-operation drops uart_wr_en immediately; the in-flight uart frame is not tracked.
- States: SEL, ISSUE, WAIT_BUSY, WAIT_DONE.
- SEL, candidate selection:
  - locked=1: only grant_id is a candidate.
  - locked=0 and enable=1: first valid index scanning ptr, ptr+1, ... mod N.
  - locked=0 and enable=0: no candidate.
- SEL, accept: with a candidate g, req_valid[g]=1 and uart_tx_busy=0, req_ready[g]=1 that cycle (combinational, one-hot). Transfer occurs on that edge. Go to ISSUE.
- SEL, no accept: otherwise req_ready=0; a locked requester that drops valid is waited for indefinitely.
- On accept:
  - uart_din <= req_data[g]; grant_id <= g.
  - LOCK_EN=1 and req_last[g]=0: locked <= 1.
  - Else: locked <= 0 and ptr <= (g+1) mod N.
- ISSUE: uart_wr_en=1 for exactly one cycle. Latency is accept edge T -> wr_en high in cycle T+1. Go to WAIT_BUSY with a timer cleared.
- WAIT_BUSY:
  - uart_tx_busy=1: go to WAIT_DONE.
  - Timer reaches BUSY_TO: set err_busy_to and go to SEL.
- WAIT_DONE: uart_tx_busy=0 -> SEL. Earliest next accept is the cycle after tx_busy falls.
- uart_din holds its value until the next accept.
- err_busy_to: err_clr clears it. If set and clear occur in the same cycle, set wins.
- Only one byte is in flight at a time; there is no internal FIFO. Backpressure is entirely via req_ready.
- enable=0 while locked: the current packet completes, then no new grants.
- Requesters must hold req_data/req_last stable while req_valid=1 and not yet accepted.

Test Plan:
- Single byte: req_valid[2]=1, data 0x55, last=1, uart in loopback -> req_ready[2] one cycle, uart_wr_en one cycle with din=0x55, rx dout=0x55, ptr=3.
- Fairness: all 4 valid with single-byte packets 0xA0..0xA3 -> uart receives A0, A1, A2, A3, A0 in that order; every req_ready pulse is one-hot.
- Packet lock: req1 sends 0x11, 0x22, 0x33 (last on 0x33) while req0 is continuously valid with 0xEE -> rx order 11, 22, 33, EE. With LOCK_EN=0 the order is 11, EE, 22, EE, 33.
- Busy timeout: uart_tx_busy tied 0 -> err_busy_to=1 exactly BUSY_TO+1 cycles after the wr_en pulse; the next request is still served; err_clr pulse -> err_busy_to=0.
- Enable gating: enable=0 mid-packet on req3 (bytes 0x01, 0x02 last) -> both bytes sent, then req0 valid gets no req_ready until enable=1.
- Reset mid-WAIT_DONE: assert rst -> uart_wr_en, locked, req_ready and grant_id are 0 in the same cycle; after release, a fresh 0xC3 request is transmitted correctly.
